// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  // Bit counter must index 0..WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Per-bit full adder built from two half adders and an OR for the carry.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (sum),
    .c (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// 1-bit half-adder cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder, LSB first, with valid/ready on both sides.
// Define SERIAL_ADDER_OVERFLOW_EN to add the o_overflow (signed overflow) port.
//
// state | meaning
// IDLE  | o_ready high, waiting for operands
// SHIFT | one full-adder step per clock, WIDTH steps total
// DONE  | o_valid high, result held until the output handshake
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_busy
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             valid_q;
  logic             fa_sum;
  logic             fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf_q;
`endif

  full_adder_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (i_valid && ready_q) begin
            a_q     <= i_a;
            b_q     <= i_b;
            carry_q <= i_cin;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            // carry_q here is the carry into the MSB
            cout_q  <= fa_cout;
            valid_q <= 1'b1;
            state_q <= DONE;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf_q   <= carry_q ^ fa_cout;
`endif
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;
  assign o_busy  = (state_q != IDLE);
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign o_overflow = ovf_q;
`endif

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder that consumes two WIDTH-bit operands plus carry-in.
- Processes one bit per clock, LSB first, through a registered carry.
- Returns the WIDTH-bit sum and carry-out with valid/ready handshakes on both sides.
- Downstream consumer of the 1-bit half-adder cell: two half adders form the per-bit full-adder stage, and this block adds the sequencing around it.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..64.

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  reset, asynchronous assert, active-low
- i_valid  input  1  upstream operands valid
- o_ready  output  1  block can accept operands
- i_a  input  WIDTH  operand A
- i_b  input  WIDTH  operand B
- i_cin  input  1  carry-in
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_sum  output  WIDTH  sum A+B+cin mod 2^WIDTH
- o_cout  output  1  carry-out of MSB
- o_busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock and reset are decided: one clock (i_clk); reset i_rst_n is asynchronous and active-low.
- Reset (i_rst_n=0, asynchronous):
  - state=IDLE.
  - o_valid=0, o_sum=0, o_cout=0, o_busy=0.
  - o_ready forced 0 while reset is asserted; goes to 1 on the first cycle after release.
  - All shift registers, carry register and bit counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid&o_ready at edge T: load A/B shift registers from i_a/i_b, carry_q<=i_cin, cnt<=0, go to SHIFT.
  - Operands are sampled only at this edge.
- SHIFT:
  - Each edge computes s=a_q[0]^b_q[0]^carry_q and carry_q<=maj(a_q[0],b_q[0],carry_q).
  - Shifts s into sum_q MSB (right shift); A/B shift right; cnt++.
  - After the edge where cnt==WIDTH-1, go to DONE.
  - Exactly WIDTH SHIFT edges: T+1..T+WIDTH.
- DONE:
  - o_valid=1 from the cycle after edge T+WIDTH.
  - o_sum/o_cout stable and held until i_valid... i.e. until the output handshake o_valid&i_ready.
  - On handshake go to IDLE; o_valid=0 and o_ready=1 the following cycle.
- Latency: o_valid rises WIDTH cycles after the acceptance edge. Minimum issue interval WIDTH+2 cycles.
- o_ready=0 in SHIFT and DONE; i_valid is ignored there and no operands are captured.
- o_sum/o_cout are meaningful only while o_valid=1; intermediate values during SHIFT are unchecked.
- Counter width: $clog2(WIDTH).
- Wrap-around: the sum is modulo 2^WIDTH; the overflow bit is reported only on o_cout.
- Reset mid-SHIFT or mid-DONE: operation aborted, result discarded, no o_valid pulse.
- Simultaneous i_valid and output handshake in DONE: no accept that cycle; accept occurs in IDLE at the earliest next cycle.

Optional Feature:
- Macro SERIAL_ADDER_OVERFLOW_EN.
- Defined:
  - Adds port o_overflow (output, 1) = signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - Captured on the final SHIFT edge, valid and held with o_sum.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package serial_adder_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - localparam helper for the counter width.
- Sub-module full_adder_cell: combinational, built from two half_adder instances plus an OR for carry. Used as the per-bit SHIFT datapath.

Test Plan:
- WIDTH=8, a=0x0F b=0x01 cin=0 -> o_sum=0x10, o_cout=0; o_valid rises exactly 8 cycles after the accept edge.
- a=0xFF b=0x01 cin=0 -> o_sum=0x00, o_cout=1; o_overflow=0 with macro.
- a=0x7F b=0x01 cin=0 -> o_sum=0x80, o_cout=0; o_overflow=1 with macro, port absent without.
- Backpressure: hold i_ready=0 for 5 cycles in DONE while driving i_valid=1 with new operands -> o_sum/o_cout unchanged, o_ready=0, nothing captured; after handshake o_ready=1 next cycle.
- Assert i_rst_n=0 during the 4th SHIFT cycle -> outputs 0 immediately (asynchronous), no o_valid; after release a=0xAA b=0x55 cin=1 -> o_sum=0x00, o_cout=1.
- a=0xFF b=0xFF cin=1 -> o_sum=0xFF, o_cout=1; back-to-back ops with i_ready=1 -> second accept no earlier than WIDTH+2 cycles after the first.
